// File: rtl/error_stats_accumulator.sv
// Window error-statistics accumulator for the exact-vs-approximate multiplier comparator.
// Optional signed bias accumulation is enabled by defining ERR_STATS_BIAS_EN.
module error_stats_accumulator #(
    parameter int N            = 8,
    parameter int LOG2_SAMPLES = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [2*N-1:0]                exact,
    input  logic [2*N-1:0]                approx,
    input  logic [2*N-1:0]                error,
    output logic [LOG2_SAMPLES:0]         sample_count,
    output logic [2*N+LOG2_SAMPLES-1:0]   err_sum,
    output logic [2*N-1:0]                mean_err,
    output logic [2*N-1:0]                max_err,
    output logic [LOG2_SAMPLES:0]         nonzero_count,
`ifdef ERR_STATS_BIAS_EN
    output logic signed [2*N+LOG2_SAMPLES:0] bias_sum,
`endif
    output logic                          done
);

    localparam int CW = LOG2_SAMPLES + 1;
    localparam int SW = 2 * N + LOG2_SAMPLES;
    localparam logic [CW-1:0] LAST_IDX = CW'((1 << LOG2_SAMPLES) - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   sample_count_q, sample_count_d;
    logic [SW-1:0]   err_sum_q, err_sum_d;
    logic [2*N-1:0]  max_err_q, max_err_d;
    logic [CW-1:0]   nonzero_count_q, nonzero_count_d;
    logic            accept;
    logic            clear;

`ifdef ERR_STATS_BIAS_EN
    logic signed [SW:0]    bias_sum_q, bias_sum_d;
    logic signed [2*N:0]   bias_diff;
`endif

    // start is only honoured outside RUN; an in-flight window is never restarted
    assign accept = in_valid && (state_q == S_RUN);
    assign clear  = start && (state_q != S_RUN);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (accept && (sample_count_q == LAST_IDX)) state_d = S_DONE;
            S_DONE:  if (start) state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        sample_count_d  = sample_count_q;
        err_sum_d       = err_sum_q;
        max_err_d       = max_err_q;
        nonzero_count_d = nonzero_count_q;
        if (clear) begin
            sample_count_d  = '0;
            err_sum_d       = '0;
            max_err_d       = '0;
            nonzero_count_d = '0;
        end else if (accept) begin
            sample_count_d = sample_count_q + CW'(1);
            err_sum_d      = err_sum_q + SW'(error);
            if (error > max_err_q) max_err_d = error;
            if (error != '0) nonzero_count_d = nonzero_count_q + CW'(1);
        end
    end

`ifdef ERR_STATS_BIAS_EN
    // 2N+1 signed difference covers the full +/- range of two unsigned 2N products
    assign bias_diff = $signed({1'b0, approx}) - $signed({1'b0, exact});

    always_comb begin
        bias_sum_d = bias_sum_q;
        if (clear)       bias_sum_d = '0;
        else if (accept) bias_sum_d = bias_sum_q + (SW+1)'(bias_diff);
    end

    always_ff @(posedge clk) begin
        if (rst) bias_sum_q <= '0;
        else     bias_sum_q <= bias_sum_d;
    end

    assign bias_sum = bias_sum_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            sample_count_q  <= '0;
            err_sum_q       <= '0;
            max_err_q       <= '0;
            nonzero_count_q <= '0;
        end else begin
            state_q         <= state_d;
            sample_count_q  <= sample_count_d;
            err_sum_q       <= err_sum_d;
            max_err_q       <= max_err_d;
            nonzero_count_q <= nonzero_count_d;
        end
    end

    assign in_ready      = (state_q == S_RUN);
    assign done          = (state_q == S_DONE);
    assign sample_count  = sample_count_q;
    assign err_sum       = err_sum_q;
    assign mean_err      = err_sum_q[SW-1:LOG2_SAMPLES];
    assign max_err       = max_err_q;
    assign nonzero_count = nonzero_count_q;

endmodule

// File: tb/tb_error_stats_accumulator.sv
// Directed bench for error_stats_accumulator with N=8, LOG2_SAMPLES=2 (4-sample window).
module tb_error_stats_accumulator;

    localparam int N  = 8;
    localparam int L2 = 2;

    logic              clk = 1'b0;
    logic              rst, start, in_valid;
    logic              in_ready, done;
    logic [2*N-1:0]    exact, approx, error;
    logic [L2:0]       sample_count, nonzero_count;
    logic [2*N+L2-1:0] err_sum;
    logic [2*N-1:0]    mean_err, max_err;
`ifdef ERR_STATS_BIAS_EN
    logic signed [2*N+L2:0] bias_sum;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    error_stats_accumulator #(.N(N), .LOG2_SAMPLES(L2)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .exact         (exact),
        .approx        (approx),
        .error         (error),
        .sample_count  (sample_count),
        .err_sum       (err_sum),
        .mean_err      (mean_err),
        .max_err       (max_err),
        .nonzero_count (nonzero_count),
`ifdef ERR_STATS_BIAS_EN
        .bias_sum      (bias_sum),
`endif
        .done          (done)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // inputs change and outputs are sampled 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int e, input int ex, input int ap);
        in_valid = 1'b1;
        error    = 16'(e);
        exact    = 16'(ex);
        approx   = 16'(ap);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic chk_all(input string tag, input int cnt, input int sum, input int mean,
                           input int mx, input int nz, input int dn, input int rdy);
        chk({tag, ".cnt"},  sample_count,  cnt);
        chk({tag, ".sum"},  err_sum,       sum);
        chk({tag, ".mean"}, mean_err,      mean);
        chk({tag, ".max"},  max_err,       mx);
        chk({tag, ".nz"},   nonzero_count, nz);
        chk({tag, ".done"}, done,          dn);
        chk({tag, ".rdy"},  in_ready,      rdy);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0;
        exact = '0; approx = '0; error = '0;
        #1;
        tick();
        tick();
        chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
`ifdef ERR_STATS_BIAS_EN
        chk("reset.bias", bias_sum, 0);
`endif
        rst = 1'b0;

        // in_valid in IDLE is ignored
        in_valid = 1'b1; error = 16'd9;
        tick(); tick(); tick();
        in_valid = 1'b0;
        chk_all("idle_valid", 0, 0, 0, 0, 0, 0, 0);

        // basic window
        do_start();
        chk_all("basic.start", 0, 0, 0, 0, 0, 0, 1);
        send(0, 0, 0);
        send(4, 0, 0);
        chk_all("basic.mid", 2, 4, 1, 4, 1, 0, 1);
        send(10, 0, 0);
        send(2, 0, 0);
        chk_all("basic.end", 4, 16, 4, 10, 3, 1, 0);
        in_valid = 1'b1; error = 16'd50;
        tick(); tick();
        in_valid = 1'b0;
        chk_all("basic.hold", 4, 16, 4, 10, 3, 1, 0);

        // restart from DONE, then max-value errors
        do_start();
        chk_all("restart.start", 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) send(65025, 0, 0);
        chk_all("restart.end", 4, 260100, 65025, 65025, 4, 1, 0);

        // stalls with an ignored start pulse in the gap
        do_start();
        send(0, 0, 0);
        send(4, 0, 0);
        tick();
        do_start();
        tick();
        chk_all("stall.gap", 2, 4, 1, 4, 1, 0, 1);
        send(10, 0, 0);
        send(2, 0, 0);
        chk_all("stall.end", 4, 16, 4, 10, 3, 1, 0);

        // reset mid-window, rst winning over in_valid and start
        do_start();
        send(5, 0, 0);
        send(7, 0, 0);
        rst = 1'b1; in_valid = 1'b1; start = 1'b1; error = 16'd3;
        tick();
        rst = 1'b0; in_valid = 1'b0; start = 1'b0;
        chk_all("midrst", 0, 0, 0, 0, 0, 0, 0);
        do_start();
        send(1, 0, 0);
        send(0, 0, 0);
        send(3, 0, 0);
        send(0, 0, 0);
        chk_all("post_rst", 4, 4, 1, 3, 2, 1, 0);

`ifdef ERR_STATS_BIAS_EN
        do_start();
        chk("bias.clear", bias_sum, 0);
        send(4, 100, 96);
        send(2, 50, 52);
        send(0, 0, 0);
        send(3, 30, 27);
        chk("bias.sum", bias_sum, -5);
        chk_all("bias.stats", 4, 9, 2, 4, 3, 1, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
